ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Controller in front of the single-port 4096x4 RAM (12-bit address, 4-bit word, synchronous write, combinational read).
- Shares the RAM between two requesters: port A (instruction fetch) and port B (data load/store).
- Arbitrates round-robin and sequences each access.
- After reset, optionally sweeps the whole RAM to zero before accepting any request.

Parameters:
- ADDR_W, 12, address width; RAM depth is 2**ADDR_W.
- DATA_W, 4, word width.
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset release; 0 = go straight to IDLE.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request.
- a_we  input  1  port A write enable (1 = write, 0 = read).
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_rdata  output  DATA_W  port A read data, valid while a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- busy  output  1  high during clear sweep or while an access is in flight.
- ram_read  output  1  RAM read strobe.
- ram_write  output  1  RAM write strobe.
- ram_addr  output  ADDR_W  RAM address.
- ram_in  output  DATA_W  RAM write data.
- ram_out  input  DATA_W  RAM read data (combinational).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - clear counter = 0.
  - last_grant = B, so A wins the first tie.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - ram_read = ram_write = 0.
  - busy = CLEAR_ON_RESET.
- Reset mid-operation aborts any access immediately. No ack is issued. A write whose edge has not yet occurred is not committed.
- CLEAR state:
  - Each cycle: ram_write=1, ram_addr = counter, ram_in = 0, ram_read = 0; counter increments.
  - After address 2**ADDR_W-1 is written (exactly 4096 cycles), go to IDLE.
  - Requests during CLEAR are held off (no ack); they are not lost.
- IDLE:
  - busy=0, RAM strobes 0.
  - If a_req or b_req is sampled high, latch the winner's we/addr/wdata and go to SERVE.
  - Both requesting: grant the port other than last_grant. Single requester: grant it regardless of last_grant.
  - last_grant updates on grant.
- SERVE (1 cycle):
  - busy=1; ram_addr and ram_in come from the latched values.
  - ram_write = latched we; ram_read = !latched we.
  - At the closing edge: write commits in the RAM, or ram_out is captured into the winner's rdata register. Go to ACK.
- ACK (1 cycle):
  - Winner's ack=1; busy=1; RAM strobes 0.
  - For reads, rdata holds the captured word. For writes, rdata is unchanged.
  - Next state IDLE.
- Latency: req sampled in cycle 0 (IDLE), ack in cycle 2. Peak throughput is one access per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack is observed.
  - On the edge ending the ack cycle, either drop req or present a new payload with req still high.
  - A request whose payload changes while pending is a protocol violation; behaviour is undefined.
- Other rules:
  - Only one ack is asserted in any cycle; a_ack and b_ack are never high together.
  - rdata registers retain their value between accesses.
  - Reads are never mutated by the other port mid-access. The port losing arbitration waits at most one access (round-robin fairness).

Test Plan:
- Reset with CLEAR_ON_RESET=1, then count cycles -> busy high for exactly 4096 cycles; ram_write pulses at addresses 0..4095 with ram_in=0; then IDLE.
- A writes 0xA to 0x123, then A reads 0x123 -> write ack at cycle 2 of the request; read ack 3 cycles after re-request, with a_rdata=0xA.
- A and B both request in the same IDLE cycle after reset -> A granted first. B acked on the next access, 3 cycles after A's ack.
- A and B both hold back-to-back requests for 8 accesses -> grants alternate A,B,A,B,...; no port is starved.
- b_req asserted during CLEAR (B reads 0xFFF) -> no ack until the sweep completes. Then b_ack with b_rdata=0x0.
- Assert rst_n=0 during SERVE of a B write of 0x5 to 0x010 -> no b_ack; ram_write drops immediately; clear sweep restarts. A subsequent read of 0x010 returns 0x0.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin controller sharing one single-port RAM (synchronous write,
//   combinational read) between an instruction-fetch port (A) and a data
//   port (B). After reset it can sweep the whole RAM to zero before serving.
//
//   Every access follows IDLE -> SERVE -> ACK. The request is sampled in
//   IDLE, the RAM is strobed for one cycle in SERVE and the winner sees a
//   one-cycle ack in ACK.
//
//   All outputs are registers. Each one is loaded with the value that
//   belongs to the state being entered on the same edge.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request payload (held until ack)
//   a_ack, a_rdata      port A completion pulse and read data
//   b_*                 same as port A, for port B
//   busy                clear sweep running or access in flight
//   ram_read/ram_write  RAM strobes
//   ram_addr/ram_in     RAM address and write data
//   ram_out             RAM read data (combinational from ram_addr)
module ram_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SERVE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO   = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO   = {ADDR_W{1'b0}};

  // Round-robin pick: B wins when it is alone, or when both request and
  // A was served last. Returns 1 for a grant to B.
  function automatic logic grant_to_b(input logic req_a, input logic req_b,
                                      input logic last_was_b);
    grant_to_b = req_b & (~req_a | ~last_was_b);
  endfunction

  // State and bookkeeping registers
  state_t              state_r,     state_s;
  logic [ADDR_W-1:0]   cnt_r,       cnt_s;       // next clear address to issue
  logic                last_b_r,    last_b_s;    // 1 = B holds the last grant
  logic                win_b_r,     win_b_s;     // winner of the access in flight

  // Output registers
  logic                a_ack_r,     a_ack_s;
  logic                b_ack_r,     b_ack_s;
  logic [DATA_W-1:0]   a_rdata_r,   a_rdata_s;
  logic [DATA_W-1:0]   b_rdata_r,   b_rdata_s;
  logic                busy_r,      busy_s;
  logic                ram_read_r,  ram_read_s;
  logic                ram_write_r, ram_write_s;
  logic [ADDR_W-1:0]   ram_addr_r,  ram_addr_s;
  logic [DATA_W-1:0]   ram_in_r,    ram_in_s;

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_b_s    = last_b_r;
    win_b_s     = win_b_r;
    a_ack_s     = 1'b0;
    b_ack_s     = 1'b0;
    a_rdata_s   = a_rdata_r;
    b_rdata_s   = b_rdata_r;
    busy_s      = 1'b0;
    ram_read_s  = 1'b0;
    ram_write_s = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_in_s    = ram_in_r;

    case (state_r)
      ST_CLEAR: begin
        // The registered strobes show the write in progress. Once the write
        // to the last address is on the bus, this edge commits it and ends
        // the sweep; otherwise issue the next address.
        if (ram_write_r && (ram_addr_r == ADDR_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          busy_s      = 1'b1;
          ram_write_s = 1'b1;
          ram_addr_s  = cnt_r;
          ram_in_s    = DATA_ZERO;
          cnt_s       = cnt_r + ADDR_ONE;
        end
      end

      ST_IDLE: begin
        if (a_req || b_req) begin
          win_b_s  = grant_to_b(a_req, b_req, last_b_r);
          last_b_s = win_b_s;
          state_s  = ST_SERVE;
          busy_s   = 1'b1;
          // The RAM-side registers double as the latched request payload.
          if (win_b_s) begin
            ram_write_s = b_we;
            ram_read_s  = ~b_we;
            ram_addr_s  = b_addr;
            ram_in_s    = b_wdata;
          end else begin
            ram_write_s = a_we;
            ram_read_s  = ~a_we;
            ram_addr_s  = a_addr;
            ram_in_s    = a_wdata;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SERVE: begin
        state_s = ST_ACK;
        busy_s  = 1'b1;
        a_ack_s = ~win_b_r;
        b_ack_s = win_b_r;
        // A read captures the combinational RAM output into the winner's
        // data register; a write leaves both data registers untouched.
        if (ram_read_r) begin
          if (win_b_r) begin
            b_rdata_s = ram_out;
          end else begin
            a_rdata_s = ram_out;
          end
        end else begin
          a_rdata_s = a_rdata_r;
        end
      end

      ST_ACK: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so a reset aborts
  // any access at once (strobes drop before the next edge can commit)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESET_STATE;
      cnt_r       <= ADDR_ZERO;
      last_b_r    <= 1'b1;
      win_b_r     <= 1'b0;
      a_ack_r     <= 1'b0;
      b_ack_r     <= 1'b0;
      a_rdata_r   <= DATA_ZERO;
      b_rdata_r   <= DATA_ZERO;
      busy_r      <= CLEAR_ON_RESET;
      ram_read_r  <= 1'b0;
      ram_write_r <= 1'b0;
      ram_addr_r  <= ADDR_ZERO;
      ram_in_r    <= DATA_ZERO;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      last_b_r    <= last_b_s;
      win_b_r     <= win_b_s;
      a_ack_r     <= a_ack_s;
      b_ack_r     <= b_ack_s;
      a_rdata_r   <= a_rdata_s;
      b_rdata_r   <= b_rdata_s;
      busy_r      <= busy_s;
      ram_read_r  <= ram_read_s;
      ram_write_r <= ram_write_s;
      ram_addr_r  <= ram_addr_s;
      ram_in_r    <= ram_in_s;
    end
  end

  assign a_ack     = a_ack_r;
  assign b_ack     = b_ack_r;
  assign a_rdata   = a_rdata_r;
  assign b_rdata   = b_rdata_r;
  assign busy      = busy_r;
  assign ram_read  = ram_read_r;
  assign ram_write = ram_write_r;
  assign ram_addr  = ram_addr_r;
  assign ram_in    = ram_in_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 4096x4 RAM attached.
//   Expected completions go into a scoreboard queue when a request is
//   driven and are popped and compared when the arbiter acks.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [3:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [3:0]  a_rdata, b_rdata;
  logic        busy, ram_read, ram_write;
  logic [11:0] ram_addr;
  logic [3:0]  ram_in, ram_out;
  logic        fill_mem;

  int n_checks;
  int n_fails;

  typedef struct packed {
    logic       port_b;
    logic       is_read;
    logic [3:0] rdata;
  } exp_t;

  exp_t sb[$];

  ram_arbiter #(.ADDR_W(12), .DATA_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
  );

  // Behavioural RAM: synchronous write, combinational read. It is
  // pre-filled with 0xF so that the clear sweep is visible on readback.
  logic [3:0] mem [0:4095];
  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 4'hF;
    end else if (ram_write) begin
      mem[ram_addr] <= ram_in;
    end
  end
  assign ram_out = mem[ram_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the ack in the current cycle against the scoreboard head.
  task automatic score(input string tag);
    exp_t e;
    check({tag, "_single_ack"}, 32'(a_ack & b_ack), 32'd0);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_port"}, 32'(b_ack), 32'(e.port_b));
      if (e.is_read) begin
        check({tag, "_rdata"}, 32'(e.port_b ? b_rdata : a_rdata), 32'(e.rdata));
      end
    end
  endtask

  // Wait (bounded) for the next ack, score it, and drop the acked req.
  task automatic wait_ack(input string tag, input int budget, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (a_ack || b_ack) begin
        got = 1'b1;
        score(tag);
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
      end
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  // Follow a clear sweep from reset release until busy drops; optionally
  // raise a B read of 0xFFF partway through.
  task automatic sweep(input string tag, input bit inject_b);
    int          busy_cnt;
    bit          wr_ok, ack_seen, done;
    logic [11:0] exp_addr;
    busy_cnt = 0; wr_ok = 1'b1; ack_seen = 1'b0; done = 1'b0; exp_addr = 12'h000;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_cnt++;
        if (!(ram_write === 1'b1 && ram_read === 1'b0 &&
              ram_addr === exp_addr && ram_in === 4'h0)) wr_ok = 1'b0;
        exp_addr++;
        if (a_ack || b_ack) ack_seen = 1'b1;
        if (inject_b && i == 100) begin
          b_req = 1'b1; b_we = 1'b0; b_addr = 12'hFFF; b_wdata = 4'h0;
          sb.push_back('{port_b: 1'b1, is_read: 1'b1, rdata: 4'h0});
        end
      end
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4096);
    check({tag, "_writes_ok"}, 32'(wr_ok), 32'd1);
    check({tag, "_no_ack"}, 32'(ack_seen), 32'd0);
    check({tag, "_idle_strobes"}, 32'(ram_write | ram_read), 32'd0);
  endtask

  // Back-to-back payload tables: A does two writes then reads them back,
  // B mixes a write, its readback, a read of A's earlier word and a write.
  logic       ta_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [11:0] ta_addr[4] = '{12'h200, 12'h201, 12'h200, 12'h201};
  logic [3:0] ta_wd   [4] = '{4'h3, 4'h6, 4'h0, 4'h0};
  logic       tb_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [11:0] tb_addr[4] = '{12'h300, 12'h300, 12'h123, 12'h301};
  logic [3:0] tb_wd   [4] = '{4'hC, 4'h0, 4'h0, 4'h7};

  initial begin
    int lat, a_i, b_i, cyc, prev, n_acks;
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; fill_mem = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 12'h000; a_wdata = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 12'h000; b_wdata = 4'h0;
    @(negedge clk);
    @(negedge clk);
    fill_mem = 1'b0;

    // Reset values
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_read",  32'(ram_read),  32'd0);
    check("rst_a_ack",     32'(a_ack),     32'd0);
    check("rst_b_ack",     32'(b_ack),     32'd0);
    check("rst_a_rdata",   32'(a_rdata),   32'd0);
    check("rst_b_rdata",   32'(b_rdata),   32'd0);

    // Clear sweep with a B read of 0xFFF held off until it completes
    rst_n = 1'b1;
    sweep("clr1", 1'b1);
    wait_ack("b_clr_rd", 6, lat);
    check("b_clr_rd_lat", 32'(lat), 32'd2);

    // A writes 0xA to 0x123, then re-requests a read of the same word
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h123; a_wdata = 4'hA;
    sb.push_back('{port_b: 1'b0, is_read: 1'b0, rdata: 4'h0});
    @(negedge clk);
    check("a_wr_serve_write", 32'(ram_write), 32'd1);
    check("a_wr_serve_read",  32'(ram_read),  32'd0);
    check("a_wr_serve_addr",  32'(ram_addr),  32'h123);
    check("a_wr_serve_data",  32'(ram_in),    32'hA);
    check("a_wr_serve_busy",  32'(busy),      32'd1);
    wait_ack("a_wr", 6, lat);
    check("a_wr_lat", 32'(lat), 32'd1);
    a_req = 1'b1; a_we = 1'b0;
    sb.push_back('{port_b: 1'b0, is_read: 1'b1, rdata: 4'hA});
    wait_ack("a_rd", 8, lat);
    check("a_rd_lat", 32'(lat), 32'd3);

    // Both ports stream 4 accesses each; A was granted last, so B leads
    @(negedge clk);
    a_i = 0; b_i = 0;
    a_req = 1'b1; a_we = ta_we[0]; a_addr = ta_addr[0]; a_wdata = ta_wd[0];
    b_req = 1'b1; b_we = tb_we[0]; b_addr = tb_addr[0]; b_wdata = tb_wd[0];
    sb.push_back('{port_b: 1'b1, is_read: 1'b0, rdata: 4'h0});
    sb.push_back('{port_b: 1'b0, is_read: 1'b0, rdata: 4'h0});
    sb.push_back('{port_b: 1'b1, is_read: 1'b1, rdata: 4'hC});
    sb.push_back('{port_b: 1'b0, is_read: 1'b0, rdata: 4'h0});
    sb.push_back('{port_b: 1'b1, is_read: 1'b1, rdata: 4'hA});
    sb.push_back('{port_b: 1'b0, is_read: 1'b1, rdata: 4'h3});
    sb.push_back('{port_b: 1'b1, is_read: 1'b0, rdata: 4'h0});
    sb.push_back('{port_b: 1'b0, is_read: 1'b1, rdata: 4'h6});
    cyc = 0; prev = -1; n_acks = 0;
    repeat (30) begin
      @(negedge clk);
      cyc++;
      if (a_ack || b_ack) begin
        n_acks++;
        score("rr");
        if (prev >= 0) check("rr_gap", 32'(cyc - prev), 32'd3);
        else check("rr_first_lat", 32'(cyc), 32'd2);
        prev = cyc;
        if (a_ack) begin
          a_i++;
          if (a_i < 4) begin
            a_we = ta_we[a_i]; a_addr = ta_addr[a_i]; a_wdata = ta_wd[a_i];
          end else begin
            a_req = 1'b0;
          end
        end
        if (b_ack) begin
          b_i++;
          if (b_i < 4) begin
            b_we = tb_we[b_i]; b_addr = tb_addr[b_i]; b_wdata = tb_wd[b_i];
          end else begin
            b_req = 1'b0;
          end
        end
      end
    end
    check("rr_ack_count", 32'(n_acks), 32'd8);
    check("rr_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during the SERVE cycle of a B write of 0x5 to 0x010
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h010; b_wdata = 4'h5;
    @(negedge clk);
    check("abort_serve_write", 32'(ram_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_write_drop", 32'(ram_write), 32'd0);
    check("abort_no_ack",     32'(b_ack),     32'd0);
    check("abort_busy",       32'(busy),      32'd1);
    check("abort_a_rdata",    32'(a_rdata),   32'd0);
    b_req = 1'b0;
    @(negedge clk);
    check("abort_no_ack_late", 32'(b_ack), 32'd0);
    rst_n = 1'b1;
    sweep("clr2", 1'b0);

    // Simultaneous requests right after reset: A first, B one access later
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h123;
    sb.push_back('{port_b: 1'b0, is_read: 1'b1, rdata: 4'h0});
    sb.push_back('{port_b: 1'b1, is_read: 1'b1, rdata: 4'h0});
    wait_ack("tie_a", 6, lat);
    check("tie_a_lat", 32'(lat), 32'd2);
    wait_ack("tie_b", 6, lat);
    check("tie_b_lat", 32'(lat), 32'd3);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
